// File: rtl/ram_arbiter_pkg.sv
// Shared types and defaults for the status-RAM arbiter and its users.
// The RAM geometry defaults match the 256x8 bram instance.
package ram_arb_pkg;

  localparam int RAM_ADDR_W = 8;
  localparam int RAM_DATA_W = 8;
  localparam int N_REQ_DEF  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  // Width of a requester index; never zero, so a 1-requester build still elaborates.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester-side bundle of the RAM arbiter: per-requester request/address/data
// going in, grant, ownership and broadcast read data coming back.
interface ram_arbiter_if
  import ram_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
);
  localparam int OWNER_W = idx_w(N_REQ);

  logic [N_REQ-1:0]             req;
  logic [N_REQ-1:0][ADDR_W-1:0] req_addr;
  logic [N_REQ-1:0][DATA_W-1:0] req_din;
  logic [N_REQ-1:0]             req_wren;
  logic [N_REQ-1:0]             gnt;
  logic [N_REQ-1:0]             rvalid;
  logic [DATA_W-1:0]            rdata;
  logic [OWNER_W-1:0]           owner;
  logic                         owner_valid;

  modport master (
    output req, req_addr, req_din, req_wren,
    input  gnt, rvalid, rdata, owner, owner_valid
  );

  modport slave (
    input  req, req_addr, req_din, req_wren,
    output gnt, rvalid, rdata, owner, owner_valid
  );

endinterface

// File: rtl/ram_arbiter_rr_pick.sv
// Combinational round-robin search: first requester after `last` (wrapping)
// that is requesting and not excluded.
module rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  input  logic [N-1:0]     excl,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [N-1:0] cand;
  logic [IDX_W:0] pos;

  // NOTE: every output of a combinational block is given a default before any
  // conditional assignment, otherwise the tool infers a latch to hold it.
  always_comb begin
    cand  = req & ~excl;
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      // One spare bit keeps last+k from overflowing before the wrap.
      pos = {1'b0, last} + (IDX_W+1)'(k);
      if (pos >= (IDX_W+1)'(N)) pos = pos - (IDX_W+1)'(N);
      if (!found && cand[pos[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = pos[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Round-robin owner arbiter for the single-port status RAM: ownership is held
// until the owner drops req, and read data is tagged back to whoever issued it.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int N_REQ  = N_REQ_DEF,
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  ram_arbiter_if.slave      bus,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_wren,
  output logic              ram_en,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int OW = idx_w(N_REQ);

  arb_state_t       state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    last_q, last_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic             rd_pend_q, rd_pend_d;
  logic [OW-1:0]    rd_idx_q, rd_idx_d;

  logic [N_REQ-1:0] excl;
  logic             found;
  logic [OW-1:0]    win;
  logic             owner_req;
  logic             access;

  assign owner_req = bus.req[owner_q];
  assign access    = (state_q == OWNED) && owner_req;
  // The outgoing owner may not win its own handoff.
  assign excl      = (state_q == OWNED) ? (N_REQ'(1) << owner_q) : '0;

  rr_pick #(
    .N     (N_REQ),
    .IDX_W (OW)
  ) u_pick (
    .req   (bus.req),
    .last  (last_q),
    .excl  (excl),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWNED;
          owner_d = win;
          last_d  = win;
          gnt_d   = N_REQ'(1) << win;
        end
      end
      OWNED: begin
        if (!owner_req) begin
          if (found) begin
            owner_d = win;
            last_d  = win;
            gnt_d   = N_REQ'(1) << win;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // RAM port follows the registered owner; idle cycles drive a quiet bus.
  always_comb begin
    ram_addr  = '0;
    ram_din   = '0;
    ram_wren  = 1'b0;
    ram_en    = 1'b0;
    rd_pend_d = 1'b0;
    rd_idx_d  = rd_idx_q;
    if (access) begin
      ram_en    = 1'b1;
      ram_addr  = bus.req_addr[owner_q];
      ram_din   = bus.req_din[owner_q];
      ram_wren  = bus.req_wren[owner_q];
      rd_pend_d = !bus.req_wren[owner_q];
      rd_idx_d  = owner_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= '0;
      last_q    <= OW'(N_REQ - 1);
      gnt_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      rd_pend_q <= rd_pend_d;
      rd_idx_q  <= rd_idx_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.owner       = owner_q;
  assign bus.owner_valid = (state_q == OWNED);
  // rd_idx_q is kept separately so a read still lands after ownership moves.
  assign bus.rvalid      = rd_pend_q ? (N_REQ'(1) << rd_idx_q) : '0;
  assign bus.rdata       = ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a cycle-level ownership/RAM model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_ram_arbiter;
  import ram_arb_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int AW = RAM_ADDR_W;
  localparam int DW = RAM_DATA_W;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_wren;
  logic          ram_en;
  logic [DW-1:0] ram_dout = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  ram_arbiter_if #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ram_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_wren (ram_wren),
    .ram_en   (ram_en),
    .ram_dout (ram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural bram: 1-cycle read latency, write-only-when-enabled.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wren) mem[ram_addr] <= ram_din;
      else          ram_dout      <= mem[ram_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit            m_has   = 1'b0;
  logic [IW-1:0] m_owner = '0;
  logic [IW-1:0] m_last  = IW'(N - 1);
  bit            m_pend  = 1'b0;
  logic [IW-1:0] m_pidx  = '0;
  logic [DW-1:0] m_rdata = '0;
  logic [DW-1:0] m_mem [256];

  function automatic int pick(input logic [N-1:0] r, input int last_i, input int excl);
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (last_i + k) % N;
      if (i != excl && r[IW'(i)]) return i;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model_step
    bit acc;
    int w;
    if (!rst_n) begin
      m_has   = 1'b0;
      m_owner = '0;
      m_last  = IW'(N - 1);
      m_pend  = 1'b0;
    end else begin
      acc    = m_has && bus.req[m_owner];
      m_pend = 1'b0;
      if (acc) begin
        if (bus.req_wren[m_owner]) begin
          m_mem[bus.req_addr[m_owner]] = bus.req_din[m_owner];
        end else begin
          m_pend  = 1'b1;
          m_pidx  = m_owner;
          m_rdata = m_mem[bus.req_addr[m_owner]];
        end
      end
      if (!m_has) begin
        w = pick(bus.req, int'(m_last), -1);
        if (w >= 0) begin
          m_has = 1'b1; m_owner = IW'(w); m_last = IW'(w);
        end
      end else if (!bus.req[m_owner]) begin
        w = pick(bus.req, int'(m_last), int'(m_owner));
        if (w >= 0) begin
          m_owner = IW'(w); m_last = IW'(w);
        end else begin
          m_has = 1'b0;
        end
      end
    end
  end

  // Every-cycle comparison, sampled on the falling edge.
  always @(negedge clk) begin : compare
    bit            acc;
    logic [N-1:0]  e_gnt;
    logic [N-1:0]  e_rv;
    acc   = m_has && bus.req[m_owner];
    e_gnt = m_has ? (N'(1) << m_owner) : '0;
    e_rv  = m_pend ? (N'(1) << m_pidx) : '0;
    check("cmp_gnt",         32'(bus.gnt),         32'(e_gnt));
    check("cmp_owner_valid", 32'(bus.owner_valid), 32'(m_has));
    check("cmp_owner",       32'(bus.owner),       32'(m_owner));
    check("cmp_rvalid",      32'(bus.rvalid),      32'(e_rv));
    check("cmp_ram_en",      32'(ram_en),          32'(acc));
    check("cmp_ram_wren",    32'(ram_wren),        acc ? 32'(bus.req_wren[m_owner]) : 32'd0);
    check("cmp_ram_addr",    32'(ram_addr),        acc ? 32'(bus.req_addr[m_owner]) : 32'd0);
    check("cmp_ram_din",     32'(ram_din),         acc ? 32'(bus.req_din[m_owner])  : 32'd0);
    if (m_pend) check("cmp_rdata", 32'(bus.rdata), 32'(m_rdata));
  end

  // ---------------- directed stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    for (int a = 0; a < 256; a++) begin
      mem[a]   = '0;
      m_mem[a] = '0;
    end
    bus.req      = 4'b1111;
    bus.req_addr = '0;
    bus.req_din  = '0;
    bus.req_wren = '0;
    rst_n        = 1'b0;

    // Reset held with everyone requesting.
    cyc(); cyc(); #2;
    check("rst_gnt",    32'(bus.gnt),    32'h0);
    check("rst_ram_en", 32'(ram_en),     32'h0);
    check("rst_rvalid", 32'(bus.rvalid), 32'h0);
    cyc(); rst_n = 1'b1; #2;
    check("rel_gnt_idle", 32'(bus.gnt), 32'h0);

    // Fairness: each owner holds 3 cycles, drops for one, then re-raises.
    for (int k = 0; k < 5; k++) begin
      cyc();
      if (k > 0) bus.req[order[k-1]] = 1'b1;
      #2;
      check("fair_gnt", 32'(bus.gnt), 32'(4'b0001 << order[k]));
      cyc(); cyc();
      cyc(); bus.req[order[k]] = 1'b0; #2;
      check("fair_hold", 32'(bus.gnt), 32'(4'b0001 << order[k]));
    end
    cyc(); bus.req = '0;
    cyc(); cyc();

    // Write 0xA5 to 0x10 then read it back, requester 2 alone.
    bus.req = 4'b0100; bus.req_addr[2] = 8'h10; bus.req_din[2] = 8'hA5; bus.req_wren[2] = 1'b1;
    #2; check("wr_gnt_wait", 32'(bus.gnt), 32'h0);
    cyc(); #2;
    check("wr_gnt",  32'(bus.gnt),  32'h4);
    check("wr_wren", 32'(ram_wren), 32'h1);
    check("wr_addr", 32'(ram_addr), 32'h10);
    check("wr_din",  32'(ram_din),  32'hA5);
    cyc(); bus.req_wren[2] = 1'b0; #2;
    check("rd_en",   32'(ram_en),   32'h1);
    check("rd_wren", 32'(ram_wren), 32'h0);
    cyc(); bus.req = '0; #2;
    check("rd_rvalid", 32'(bus.rvalid), 32'h4);
    check("rd_rdata",  32'(bus.rdata),  32'hA5);
    cyc(); #2;
    check("rd_gnt_off", 32'(bus.gnt), 32'h0);

    // Isolation: requester 1 tries to write 0xFF to 0x20 while 0 owns.
    cyc(); bus.req = 4'b0001; bus.req_addr[0] = 8'h30; bus.req_wren[0] = 1'b0;
    cyc();
    bus.req = 4'b0011; bus.req_addr[1] = 8'h20; bus.req_din[1] = 8'hFF; bus.req_wren[1] = 1'b1;
    #2;
    check("iso_gnt",  32'(bus.gnt),  32'h1);
    check("iso_wren", 32'(ram_wren), 32'h0);
    check("iso_addr", 32'(ram_addr), 32'h30);
    cyc(); bus.req_addr[0] = 8'h20; #2;
    check("iso_nopreempt", 32'(bus.gnt), 32'h1);
    // Handoff during read: 0 reads 0x10 this cycle, then drops req.
    cyc(); bus.req_addr[0] = 8'h10; bus.req_wren[1] = 1'b0; #2;
    check("iso_rvalid", 32'(bus.rvalid), 32'h1);
    check("iso_rdata",  32'(bus.rdata),  32'h00);
    cyc(); bus.req = 4'b0010; #2;
    check("ho_rvalid", 32'(bus.rvalid), 32'h1);
    check("ho_rdata",  32'(bus.rdata),  32'hA5);
    check("ho_gnt_old", 32'(bus.gnt),   32'h1);
    cyc(); #2;
    check("ho_gnt_new", 32'(bus.gnt),  32'h2);
    check("ho_owner",   32'(bus.owner), 32'h1);
    cyc(); bus.req = '0; #2;
    check("iso_rvalid1", 32'(bus.rvalid), 32'h2);
    check("iso_rdata1",  32'(bus.rdata),  32'h00);
    cyc(); cyc();

    // Reset pulse between a read and its rvalid.
    bus.req = 4'b0100; bus.req_addr[2] = 8'h10; bus.req_wren[2] = 1'b0;
    cyc(); #2;
    check("mr_gnt",    32'(bus.gnt), 32'h4);
    check("mr_ram_en", 32'(ram_en),  32'h1);
    #1; bus.req = 4'b1111; rst_n = 1'b0;
    #2;
    check("mr_gnt_rst",    32'(bus.gnt),         32'h0);
    check("mr_rvalid_rst", 32'(bus.rvalid),      32'h0);
    check("mr_ov_rst",     32'(bus.owner_valid), 32'h0);
    check("mr_en_rst",     32'(ram_en),          32'h0);
    #1; rst_n = 1'b1;
    cyc(); #2;
    check("mr_rvalid_drop", 32'(bus.rvalid), 32'h0);
    check("mr_gnt_restart", 32'(bus.gnt),    32'h1);
    check("mr_owner",       32'(bus.owner),  32'h0);
    cyc(); bus.req = '0;
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
